// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the core it feeds:
// sequencer states, the NOP encoding and the default end-of-run opcode.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

    localparam logic [5:0] NOP_INSTR       = 6'h00;
    localparam logic [5:0] DEFAULT_HALT_OP = 6'h3F;

endpackage

// File: rtl/instr_sequencer_prog_store.sv
// Program store: DEPTH x 6-bit words, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module prog_store #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [5:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [5:0]    o_rdata
);

    logic [5:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Feeds a stored program to the core one word per cycle, holding the core in
// reset outside a run and bounding each run with a step watchdog.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter logic [5:0]  HALT_OP   = DEFAULT_HALT_OP,
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [5:0]               load_data,
    input  logic                     start,
    input  logic                     halt_req,
    input  logic                     cjump,
    output logic [5:0]               instr,
    output logic                     core_rst,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     running,
    output logic                     done,
    output logic                     timeout
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [7:0]  STEP_LAST = 8'(MAX_STEPS - 1);
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    seq_state_e    r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [7:0]    r_steps, w_steps_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic [5:0]    w_mem_rd;
    logic          w_run;
    logic          w_we;

    assign w_run = (r_state == RUN);
    // Writes are blocked while the core is executing so the running program is stable.
    assign w_we  = load_en && !w_run;

    prog_store #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_store (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (r_pc),
        .o_rdata (w_mem_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_steps   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_steps   <= w_steps_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_steps_nxt   = r_steps;
        w_timeout_nxt = r_timeout;
        unique case (r_state)
            IDLE, HALT: begin
                if (start) begin
                    w_state_nxt   = RUN;
                    w_pc_nxt      = '0;
                    w_steps_nxt   = '0;
                    w_timeout_nxt = 1'b0;
                end
            end
            RUN: begin
                if (r_steps != 8'hFF) begin
                    w_steps_nxt = r_steps + 8'd1;
                end
                if (halt_req) begin
                    w_state_nxt = HALT;
                end else if (w_mem_rd == HALT_OP) begin
                    w_state_nxt = HALT;
                end else if (r_steps == STEP_LAST) begin
                    w_state_nxt   = HALT;
                    w_timeout_nxt = 1'b1;
                end else if (cjump) begin
                    w_pc_nxt = w_mem_rd[AW-1:0];
                end else begin
                    w_pc_nxt = (r_pc == PC_LAST) ? '0 : r_pc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign instr    = w_run ? w_mem_rd : NOP_INSTR;
    assign core_rst = !w_run;
    assign running  = w_run;
    assign done     = (r_state == HALT);
    assign timeout  = r_timeout;
    assign pc       = r_pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: each scenario queues the expected
// per-cycle outputs as it drives stimulus and pops one entry per cycle.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [5:0]    load_data;
    logic          start;
    logic          halt_req;
    logic          cjump;
    logic [5:0]    instr;
    logic          core_rst;
    logic [AW-1:0] pc;
    logic          running;
    logic          done;
    logic          timeout;

    // {instr[13:8], pc[7:4], core_rst, running, done, timeout}
    logic [13:0] w_obs;
    assign w_obs = {instr, pc, core_rst, running, done, timeout};

    typedef struct {
        logic [13:0] exp;
        logic [13:0] mask;
    } sb_t;

    localparam logic [13:0] M_ALL  = 14'h3FFF;
    localparam logic [13:0] M_NOPC = 14'h3F0F;

    sb_t sbq[$];
    sb_t sb;
    int  n_checks = 0;
    int  n_err    = 0;

    instr_sequencer #(
        .DEPTH     (16),
        .HALT_OP   (6'h3F),
        .MAX_STEPS (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .halt_req  (halt_req),
        .cjump     (cjump),
        .instr     (instr),
        .core_rst  (core_rst),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit reached: got=no_finish required=finish");
        $fatal(1, "time limit");
    end

    function automatic void push_run(input logic [5:0] ins, input logic [AW-1:0] p);
        sbq.push_back('{{ins, p, 4'b0100}, M_ALL});
    endfunction

    function automatic void push_halt(input logic to);
        sbq.push_back('{{6'h00, 4'h0, 3'b101, to}, M_NOPC});
    endfunction

    function automatic void push_idle();
        sbq.push_back('{{6'h00, 4'h0, 4'b1000}, M_ALL});
    endfunction

    task automatic load_word(input logic [AW-1:0] a, input logic [5:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b1; halt_req = 1'b0; cjump = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b0;
        // release of reset must not start a run on its own
        repeat (4) push_idle();
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL reset cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            if (c == 0) rst = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_basic_run();
        load_word(4'd0, 6'h01);
        load_word(4'd1, 6'h02);
        load_word(4'd2, 6'h03);
        load_word(4'd3, 6'h3F);
        kick();
        push_run(6'h01, 4'd0); push_run(6'h02, 4'd1);
        push_run(6'h03, 4'd2); push_run(6'h3F, 4'd3);
        repeat (3) push_halt(1'b0);
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL basic_run cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            // halt_req and cjump are don't-cares once halted
            halt_req = (c >= 4);
            cjump    = (c >= 4);
            @(negedge clk);
        end
        halt_req = 1'b0; cjump = 1'b0;
    endtask

    task automatic test_cjump();
        load_word(4'd0, 6'h01);
        load_word(4'd1, 6'h01);
        load_word(4'd2, 6'h05);
        load_word(4'd5, 6'h0A);
        load_word(4'd6, 6'h3F);
        kick();
        push_run(6'h01, 4'd0); push_run(6'h01, 4'd1); push_run(6'h05, 4'd2);
        push_run(6'h0A, 4'd5); push_run(6'h3F, 4'd6);
        push_halt(1'b0);
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL cjump cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            cjump = (c == 2);
            @(negedge clk);
        end
        cjump = 1'b0;
    endtask

    task automatic test_watchdog();
        for (int a = 0; a < 16; a++) load_word(AW'(a), 6'h01);
        kick();
        for (int k = 0; k < 20; k++) push_run(6'h01, AW'(k % 16));
        repeat (2) push_halt(1'b1);
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL watchdog cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt_req();
        kick();
        push_run(6'h01, 4'd0); push_run(6'h01, 4'd1); push_run(6'h01, 4'd2);
        repeat (2) push_halt(1'b0);
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL halt_req cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            load_en   = (c == 1);
            load_addr = 4'd5;
            load_data = 6'h2A;
            halt_req  = (c == 2);
            @(negedge clk);
        end
        load_en = 1'b0; halt_req = 1'b0;
        // second run: mem[5] must still hold 01; start mid-run must not restart
        kick();
        for (int k = 0; k < 6; k++) push_run(6'h01, AW'(k));
        push_halt(1'b0);
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL run_load_ignored cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            start    = (c == 2);
            halt_req = (c == 5);
            @(negedge clk);
        end
        start = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_load_start_same_cycle();
        load_en = 1'b1; load_addr = 4'd0; load_data = 6'h3F;
        start = 1'b1;
        @(negedge clk);
        load_en = 1'b0; start = 1'b0;
        push_run(6'h3F, 4'd0);
        push_halt(1'b0);
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL load_start cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_midrun();
        load_word(4'd0, 6'h01);
        load_word(4'd1, 6'h02);
        load_word(4'd2, 6'h03);
        load_word(4'd3, 6'h3F);
        kick();
        push_run(6'h01, 4'd0); push_run(6'h02, 4'd1);
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL rst_pre cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            @(negedge clk);
        end
        // assert reset between edges; outputs must respond without a clock
        #2 rst = 1'b0;
        #1;
        push_idle(); push_idle(); push_idle(); push_idle();
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL rst_async cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            if (c == 0) @(negedge clk);
            else begin
                rst = 1'b1;
                @(negedge clk);
            end
        end
        kick();
        push_run(6'h01, 4'd0); push_run(6'h02, 4'd1);
        push_run(6'h03, 4'd2); push_run(6'h3F, 4'd3);
        push_halt(1'b0);
        for (int c = 0; sbq.size() > 0; c++) begin
            sb = sbq.pop_front();
            n_checks++;
            if ((w_obs & sb.mask) !== (sb.exp & sb.mask)) begin
                n_err++;
                $display("FAIL rst_replay cyc=%0d got=%h exp=%h mask=%h", c, w_obs, sb.exp, sb.mask);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_cjump();
        test_watchdog();
        test_halt_req();
        test_load_start_same_cycle();
        test_rst_midrun();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
